vga_frame_commit: RTL and testbench

//  Frame-synchronous commit controller for the player-state vectors (p1VGA/p2VGA) feeding vga_controller.
//  The processor, through the mmio decode, writes 32-bit words into per-player shadow registers at any time.
//  The live 128-bit vectors update only on a requested commit, at the next vertical-sync start, so no frame tears.

---
 rtl/vga_frame_commit.sv | 127 ++++++++++++
 tb/tb_vga_frame_commit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_commit.sv
// Frame-synchronous commit controller for the player-state vectors.
// The processor writes words into per-player shadow registers at any time;
// the live vectors take the shadow contents only when a commit has been
// requested, at the next falling edge of VGA vertical sync, so a frame never
// shows a half-updated state.
//
// Handshake: wr_en, commit_req and overrun_clr are single-cycle strobes
// sampled on the rising clock edge. There is no back-pressure. The processor
// polls busy to learn whether a commit is still pending, and it polls
// frame_cnt to see that a commit has completed.
module vga_frame_commit #(
  parameter int WORD_W      = 32,
  parameter int SLOTS       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  localparam int VEC_W      = WORD_W * SLOTS,
  localparam int SLOT_W     = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic              wr_player,
  input  logic [SLOT_W-1:0] wr_slot,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              commit_req,
  input  logic              overrun_clr,
  input  logic              vga_vs,
  output logic              busy,
  output logic              overrun,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [VEC_W-1:0]  p1VGA,
  output logic [VEC_W-1:0]  p2VGA,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COPY  = 2'd2
  } state_e;

  state_e                          state_q, state_d;
  logic [SLOTS-1:0][WORD_W-1:0]    sh_p1_q, sh_p2_q;
  logic [VEC_W-1:0]                p1_q, p2_q;
  logic [CNT_W-1:0]                frame_cnt_q;
  logic                            overrun_q;
  logic                            overrun_set;
  logic [SYNC_STAGES-1:0]          vs_sync_q;
  logic                            vs_prev_q;
  logic                            vs_s;
  logic                            vs_fall;

  // Shadow registers: a write lands in the addressed slot in every FSM state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sh_p1_q <= '0;
      sh_p2_q <= '0;
    end else if (wr_en) begin
      if (wr_player) sh_p2_q[wr_slot] <= wr_data;
      else           sh_p1_q[wr_slot] <= wr_data;
    end
  end

  // Synchronise the asynchronous vertical sync; idle level is high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vs_sync_q <= '1;
      vs_prev_q <= 1'b1;
    end else begin
      vs_sync_q <= {vs_sync_q[SYNC_STAGES-2:0], vga_vs};
      vs_prev_q <= vs_s;
    end
  end

  assign vs_s    = vs_sync_q[SYNC_STAGES-1];
  assign vs_fall = vs_prev_q & ~vs_s;

  // Next-state decode; a request while already armed is coalesced and flagged.
  always_comb begin
    state_d     = state_q;
    overrun_set = 1'b0;
    case (state_q)
      IDLE: begin
        // A sync edge is ignored here, even alongside a fresh request.
        if (commit_req) state_d = ARMED;
      end
      ARMED: begin
        if (vs_fall)    state_d = COPY;
        if (commit_req) overrun_set = 1'b1;
      end
      COPY: begin
        state_d = commit_req ? ARMED : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM register plus the live vectors, frame counter and sticky overrun.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      p1_q        <= '0;
      p2_q        <= '0;
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      // Set has priority over clear when both happen in one cycle.
      overrun_q <= overrun_set | (overrun_q & ~overrun_clr);
      if (state_q == COPY) begin
        // Shadows as registered at the start of COPY; a write during COPY
        // is only picked up by a later commit.
        p1_q        <= sh_p1_q;
        p2_q        <= sh_p2_q;
        frame_cnt_q <= frame_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;
  assign frame_cnt = frame_cnt_q;
  assign p1VGA     = p1_q;
  assign p2VGA     = p2_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_vga_frame_commit.sv
// Directed bench for vga_frame_commit. Inputs change on the falling clock
// edge and outputs are checked there too, half a cycle after the active edge.
// A second instance with a 4-bit frame counter shares every input so the
// counter wrap can be reached in a few commits.
module tb_vga_frame_commit;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         wr_en;
  logic         wr_player;
  logic [1:0]   wr_slot;
  logic [31:0]  wr_data;
  logic         commit_req;
  logic         overrun_clr;
  logic         vga_vs;
  logic         busy;
  logic         overrun;
  logic [15:0]  frame_cnt;
  logic [127:0] p1VGA;
  logic [127:0] p2VGA;
  logic [1:0]   state_dbg;

  logic         busy_w;
  logic         overrun_w;
  logic [3:0]   frame_cnt_w;
  logic [127:0] p1_w;
  logic [127:0] p2_w;
  logic [1:0]   state_dbg_w;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  localparam logic [127:0] P1_A = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] P1_B = 128'h44444444_33333333_22222222_AAAAAAAA;
  localparam logic [127:0] P2_D = 128'h00000000_DEADBEEF_00000000_00000000;

  vga_frame_commit dut (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_player(wr_player),
    .wr_slot(wr_slot), .wr_data(wr_data), .commit_req(commit_req),
    .overrun_clr(overrun_clr), .vga_vs(vga_vs), .busy(busy), .overrun(overrun),
    .frame_cnt(frame_cnt), .p1VGA(p1VGA), .p2VGA(p2VGA), .state_dbg(state_dbg)
  );

  vga_frame_commit #(.CNT_W(4)) dut_w (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_player(wr_player),
    .wr_slot(wr_slot), .wr_data(wr_data), .commit_req(commit_req),
    .overrun_clr(overrun_clr), .vga_vs(vga_vs), .busy(busy_w), .overrun(overrun_w),
    .frame_cnt(frame_cnt_w), .p1VGA(p1_w), .p2VGA(p2_w), .state_dbg(state_dbg_w)
  );

  // Clock / reset block
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Driver tasks: each starts at a falling edge and ends at the next one.
  task automatic write_word(input logic player, input logic [1:0] slot, input logic [31:0] data);
    wr_en = 1'b1; wr_player = player; wr_slot = slot; wr_data = data;
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  task automatic commit();
    commit_req = 1'b1;
    @(negedge clock);
    commit_req = 1'b0;
  endtask

  // Falling sync; four edges covers synchroniser, ARMED->COPY and COPY end.
  task automatic frame_fall();
    vga_vs = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic frame_rise();
    vga_vs = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  initial begin
    reset_n = 1'b0; wr_en = 1'b0; wr_player = 1'b0; wr_slot = 2'd0; wr_data = '0;
    commit_req = 1'b0; overrun_clr = 1'b0; vga_vs = 1'b1;
    repeat (2) @(negedge clock);

    // Reset state
    chk("rst_p1", p1VGA, '0);
    chk("rst_p2", p2VGA, '0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_state", state_dbg, 0);
    reset_n = 1'b1;
    @(negedge clock);

    // 1: writes alone never touch the live vector
    write_word(1'b0, 2'd0, 32'h11111111);
    write_word(1'b0, 2'd1, 32'h22222222);
    write_word(1'b0, 2'd2, 32'h33333333);
    write_word(1'b0, 2'd3, 32'h44444444);
    chk("t1_p1", p1VGA, '0);
    chk("t1_busy", busy, 0);

    // 2: commit, then sync falls; copy lands two edges after vs_fall
    commit();
    chk("t2_busy_armed", busy, 1);
    chk("t2_state_armed", state_dbg, 1);
    vga_vs = 1'b0;
    repeat (2) @(negedge clock);
    chk("t2_p1_at_fall", p1VGA, '0);
    @(negedge clock);
    chk("t2_state_copy", state_dbg, 2);
    chk("t2_p1_in_copy", p1VGA, '0);
    @(negedge clock);
    chk("t2_p1", p1VGA, P1_A);
    chk("t2_cnt", frame_cnt, 1);
    chk("t2_busy_done", busy, 0);
    frame_rise();

    // 3: request coinciding with vs_fall from IDLE waits a full frame
    write_word(1'b0, 2'd0, 32'hAAAAAAAA);
    vga_vs = 1'b0;
    repeat (2) @(negedge clock);
    commit_req = 1'b1;
    @(negedge clock);
    commit_req = 1'b0;
    chk("t3_busy", busy, 1);
    repeat (2) @(negedge clock);
    chk("t3_no_copy_p1", p1VGA, P1_A);
    chk("t3_no_copy_cnt", frame_cnt, 1);
    frame_rise();
    chk("t3_still_armed", state_dbg, 1);
    frame_fall();
    chk("t3_p1", p1VGA, P1_B);
    chk("t3_cnt", frame_cnt, 2);
    chk("t3_idle", busy, 0);
    frame_rise();

    // 4: second request while armed -> overrun, one copy only
    commit();
    chk("t4_ovr_first", overrun, 0);
    commit();
    chk("t4_ovr_set", overrun, 1);
    frame_fall();
    chk("t4_cnt", frame_cnt, 3);
    chk("t4_idle", busy, 0);
    frame_rise();
    frame_fall();
    chk("t4_single_copy", frame_cnt, 3);
    frame_rise();
    overrun_clr = 1'b1;
    @(negedge clock);
    overrun_clr = 1'b0;
    chk("t4_ovr_clr", overrun, 0);
    commit();
    commit_req = 1'b1; overrun_clr = 1'b1;
    @(negedge clock);
    commit_req = 1'b0; overrun_clr = 1'b0;
    chk("t4_set_wins", overrun, 1);
    frame_fall();
    chk("t4_cnt2", frame_cnt, 4);
    frame_rise();
    overrun_clr = 1'b1;
    @(negedge clock);
    overrun_clr = 1'b0;

    // 5: write during COPY is held for the next commit
    commit();
    vga_vs = 1'b0;
    repeat (3) @(negedge clock);
    chk("t5_in_copy", state_dbg, 2);
    write_word(1'b1, 2'd2, 32'hDEADBEEF);
    chk("t5_p2_unchanged", p2VGA, '0);
    chk("t5_cnt", frame_cnt, 5);
    frame_rise();
    commit();
    vga_vs = 1'b0;
    repeat (3) @(negedge clock);
    commit_req = 1'b1;           // request during COPY re-arms
    @(negedge clock);
    commit_req = 1'b0;
    chk("t5_p2", p2VGA, P2_D);
    chk("t5_cnt2", frame_cnt, 6);
    chk("t5_rearmed", state_dbg, 1);
    chk("t5_no_ovr", overrun, 0);
    frame_rise();
    frame_fall();
    chk("t5_cnt3", frame_cnt, 7);
    frame_rise();

    // 6: asynchronous reset while armed
    commit();
    chk("t6_armed", state_dbg, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_p1", p1VGA, '0);
    chk("t6_p2", p2VGA, '0);
    chk("t6_busy", busy, 0);
    chk("t6_cnt", frame_cnt, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    frame_fall();
    chk("t6_no_copy", frame_cnt, 0);
    chk("t6_idle", busy, 0);
    frame_rise();

    // Counter wrap on the 4-bit instance; shadows were cleared by reset
    for (int i = 0; i < 15; i++) begin
      commit();
      frame_fall();
      frame_rise();
    end
    chk("wrap_p1_cleared", p1VGA, '0);
    chk("wrap_cnt15", frame_cnt, 15);
    chk("wrap_small_f", frame_cnt_w, 4'hF);
    commit();
    frame_fall();
    chk("wrap_cnt16", frame_cnt, 16);
    chk("wrap_small_0", frame_cnt_w, 4'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
